// File: rtl/csi_pkt_sequencer.sv
// rtl/csi_pkt_sequencer.sv - CSI-2 frame/line packet header sequencer with delayed payload path
module csi_pkt_sequencer #(
  parameter int          LANES  = 1,
  parameter int          DELAY  = 3,
  parameter int          HW     = 16,
  parameter logic [15:0] FN_MAX = 16'd0
) (
  input  logic                 hf_clk90,
  input  logic                 reset_n_byte,
  input  logic                 fv_start_i,
  input  logic                 fv_end_i,
  input  logic                 lv_start_i,
  input  logic                 lv_end_i,
  input  logic                 byte_en_i,
  input  logic [8*LANES-1:0]   byte_data_i,
  input  logic                 d_hs_rdy_i,
  input  logic [1:0]           mode_i,
  input  logic [HW-1:0]        h_size_i,
  input  logic [1:0]           vc_i,
  output logic                 sp_en_o,
  output logic                 lp_en_o,
  output logic [5:0]           dt_o,
  output logic [1:0]           vc_o,
  output logic [HW-1:0]        wc_o,
  output logic                 byte_en_o,
  output logic [8*LANES-1:0]   byte_data_o,
  output logic                 txfr_en_o,
  output logic [15:0]          line_cnt_o,
  output logic                 len_err_o,
  output logic                 seq_err_o,
  output logic                 cfg_err_o
);

  localparam int BW = 8 * LANES;
  localparam logic [HW-1:0] FN_WRAP = HW'(FN_MAX);

  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_LINE} state_t;

  state_t          state, state_nxt;
  logic            acc_fs, acc_fe, acc_ls, acc_le, seq_err_nxt;
  logic [1:0]      mode_r;
  logic [HW-1:0]   wc_line, byte_cnt, fn;
  logic [HW-1:0]   wc_new, cnt_inc, fn_wc, fn_nxt;
  logic [HW:0]     cnt_sum;
  logic            cfg_bad;
  logic [5:0]      dt_line;
  logic [BW:0]     pipe [DELAY];

  always_ff @(posedge hf_clk90 or negedge reset_n_byte) begin
    if (!reset_n_byte) state <= S_IDLE;
    else               state <= state_nxt;
  end

  // Only the highest-priority event is considered; anything else in the same cycle is a sequence error.
  always_comb begin
    acc_fs      = 1'b0;
    acc_fe      = 1'b0;
    acc_ls      = 1'b0;
    acc_le      = 1'b0;
    seq_err_nxt = 1'b0;
    state_nxt   = state;
    if (fv_start_i) begin
      seq_err_nxt = fv_end_i | lv_start_i | lv_end_i | (state != S_IDLE);
      acc_fs      = (state == S_IDLE);
    end else if (fv_end_i) begin
      seq_err_nxt = lv_start_i | lv_end_i | (state != S_FRAME);
      acc_fe      = (state != S_IDLE);
    end else if (lv_start_i) begin
      seq_err_nxt = lv_end_i | (state != S_FRAME);
      acc_ls      = (state == S_FRAME);
    end else if (lv_end_i) begin
      seq_err_nxt = (state != S_LINE);
      acc_le      = (state == S_LINE);
    end
    if (acc_fs)      state_nxt = S_FRAME;
    else if (acc_fe) state_nxt = S_IDLE;
    else if (acc_ls) state_nxt = S_LINE;
    else if (acc_le) state_nxt = S_FRAME;
  end

  always_comb begin
    unique case (mode_i)
      2'd1:    wc_new = h_size_i + (h_size_i >> 2);
      2'd2:    wc_new = h_size_i + (h_size_i >> 1);
      default: wc_new = h_size_i;
    endcase
    cfg_bad = (mode_i == 2'd3) || (h_size_i == '0) ||
              ((mode_i == 2'd1) && (h_size_i[1:0] != 2'b00)) ||
              ((mode_i == 2'd2) && h_size_i[0]);
    unique case (mode_r)
      2'd1:    dt_line = 6'h2B;
      2'd2:    dt_line = 6'h2C;
      default: dt_line = 6'h2A;
    endcase
    cnt_sum = {1'b0, byte_cnt} + (byte_en_i ? (HW+1)'(LANES) : '0);
    cnt_inc = cnt_sum[HW] ? '1 : cnt_sum[HW-1:0];
    fn_wc   = (FN_WRAP == '0) ? '0 : fn;
    fn_nxt  = (FN_WRAP == '0) ? fn : ((fn == FN_WRAP) ? HW'(1) : fn + HW'(1));
  end

  always_ff @(posedge hf_clk90 or negedge reset_n_byte) begin
    if (!reset_n_byte) begin
      sp_en_o    <= 1'b0;
      lp_en_o    <= 1'b0;
      dt_o       <= '0;
      vc_o       <= '0;
      wc_o       <= '0;
      txfr_en_o  <= 1'b0;
      line_cnt_o <= '0;
      len_err_o  <= 1'b0;
      seq_err_o  <= 1'b0;
      cfg_err_o  <= 1'b0;
      mode_r     <= '0;
      wc_line    <= '0;
      byte_cnt   <= '0;
      fn         <= HW'(1);
    end else begin
      sp_en_o   <= 1'b0;
      lp_en_o   <= 1'b0;
      len_err_o <= 1'b0;
      cfg_err_o <= 1'b0;
      seq_err_o <= seq_err_nxt;
      txfr_en_o <= d_hs_rdy_i;
      if (acc_ls)                         byte_cnt <= '0;
      else if (state == S_LINE && byte_en_i) byte_cnt <= cnt_inc;
      if (acc_fs) begin
        mode_r     <= mode_i;
        wc_line    <= wc_new;
        cfg_err_o  <= cfg_bad;
        vc_o       <= vc_i;
        sp_en_o    <= 1'b1;
        dt_o       <= 6'h00;
        wc_o       <= fn_wc;
        line_cnt_o <= '0;
      end
      if (acc_fe) begin
        sp_en_o <= 1'b1;
        dt_o    <= 6'h01;
        wc_o    <= fn_wc;
        fn      <= fn_nxt;
        if (state == S_LINE) len_err_o <= (cnt_inc != wc_line);
      end
      if (acc_ls) begin
        lp_en_o <= 1'b1;
        dt_o    <= dt_line;
        wc_o    <= wc_line;
      end
      if (acc_le) begin
        len_err_o  <= (cnt_inc != wc_line);
        line_cnt_o <= line_cnt_o + 16'd1;
      end
    end
  end

  always_ff @(posedge hf_clk90 or negedge reset_n_byte) begin
    if (!reset_n_byte) begin
      for (int i = 0; i < DELAY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {byte_en_i, byte_data_i};
      for (int i = 1; i < DELAY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign {byte_en_o, byte_data_o} = pipe[DELAY-1];

endmodule

// File: tb/tb_csi_pkt_sequencer.sv
// tb/tb_csi_pkt_sequencer.sv - randomized self-checking bench for csi_pkt_sequencer
module tb_csi_pkt_sequencer;
  localparam int          LANES  = 1;
  localparam int          DELAY  = 3;
  localparam int          HW     = 16;
  localparam logic [15:0] FN_MAX = 16'd2;

  logic hf_clk90 = 1'b0, reset_n_byte = 1'b0;
  logic fv_start_i = 0, fv_end_i = 0, lv_start_i = 0, lv_end_i = 0, byte_en_i = 0, d_hs_rdy_i = 0;
  logic [7:0] byte_data_i = '0;
  logic [1:0] mode_i = '0, vc_i = '0;
  logic [HW-1:0] h_size_i = '0;
  logic sp_en_o, lp_en_o, byte_en_o, txfr_en_o, len_err_o, seq_err_o, cfg_err_o;
  logic [5:0] dt_o;
  logic [1:0] vc_o;
  logic [HW-1:0] wc_o;
  logic [7:0] byte_data_o;
  logic [15:0] line_cnt_o;

  int total = 0, bad = 0, frames_done = 0;

  csi_pkt_sequencer #(.LANES(LANES), .DELAY(DELAY), .HW(HW), .FN_MAX(FN_MAX)) dut (
    .hf_clk90(hf_clk90), .reset_n_byte(reset_n_byte),
    .fv_start_i(fv_start_i), .fv_end_i(fv_end_i), .lv_start_i(lv_start_i), .lv_end_i(lv_end_i),
    .byte_en_i(byte_en_i), .byte_data_i(byte_data_i), .d_hs_rdy_i(d_hs_rdy_i),
    .mode_i(mode_i), .h_size_i(h_size_i), .vc_i(vc_i),
    .sp_en_o(sp_en_o), .lp_en_o(lp_en_o), .dt_o(dt_o), .vc_o(vc_o), .wc_o(wc_o),
    .byte_en_o(byte_en_o), .byte_data_o(byte_data_o), .txfr_en_o(txfr_en_o),
    .line_cnt_o(line_cnt_o), .len_err_o(len_err_o), .seq_err_o(seq_err_o), .cfg_err_o(cfg_err_o));

  always #5 hf_clk90 = ~hf_clk90;

  // Payload and HS-ready follow pure delay lines: a queue of what went in stands in for the pipe.
  logic [8:0] pq[$];
  logic [8:0] exp_pay;
  logic exp_tx;
  always begin
    @(posedge hf_clk90);
    if (!reset_n_byte) begin
      pq = {};
      for (int i = 0; i < DELAY - 1; i++) pq.push_back(9'd0);
      exp_pay = '0; exp_tx = 1'b0;
    end else begin
      pq.push_back({byte_en_i, byte_data_i});
      exp_pay = pq.pop_front();
      exp_tx = d_hs_rdy_i;
    end
    #1;
    if (reset_n_byte) begin
      total++; if ({byte_en_o, byte_data_o} !== exp_pay) begin bad++; $display("FAIL payload act=%0h exp=%0h", {byte_en_o, byte_data_o}, exp_pay); end
      total++; if (txfr_en_o !== exp_tx) begin bad++; $display("FAIL txfr_en act=%0d exp=%0d", txfr_en_o, exp_tx); end
    end
  end

  task automatic cyc(input bit fs, input bit fe, input bit ls, input bit le, input bit en);
    fv_start_i = fs; fv_end_i = fe; lv_start_i = ls; lv_end_i = le; byte_en_i = en;
    byte_data_i = 8'($urandom); d_hs_rdy_i = 1'($urandom);
    @(posedge hf_clk90); #1;
  endtask

  function automatic int model_wc(input int mode, input int h);
    case (mode)
      1: return (h + h / 4) % 65536;
      2: return (h + h / 2) % 65536;
      default: return h;
    endcase
  endfunction

  function automatic bit model_cfg(input int mode, input int h);
    return (mode == 3) || (h == 0) || (mode == 1 && h % 4 != 0) || (mode == 2 && h % 2 != 0);
  endfunction

  function automatic int model_fn();
    return (FN_MAX == 0) ? 0 : (frames_done % int'(FN_MAX)) + 1;
  endfunction

  // One well-formed frame; line err_line carries wc+delta strobes instead of wc.
  task automatic run_frame(input int mode, input int h, input int vc, input int nlines,
                           input int err_line, input int delta, input string tag);
    int wc, fn, n, sent;
    bit on_le, e;
    wc = model_wc(mode, h);
    fn = model_fn();
    mode_i = 2'(mode); h_size_i = HW'(h); vc_i = 2'(vc);
    cyc(1, 0, 0, 0, 0);
    total++; if ({sp_en_o, lp_en_o, dt_o} !== {2'b10, 6'h00}) begin bad++; $display("FAIL %s fs_hdr act=%0h exp=%0h", tag, {sp_en_o, lp_en_o, dt_o}, {2'b10, 6'h00}); end
    total++; if (wc_o !== HW'(fn)) begin bad++; $display("FAIL %s fs_wc act=%0d exp=%0d", tag, wc_o, fn); end
    total++; if (vc_o !== 2'(vc)) begin bad++; $display("FAIL %s fs_vc act=%0d exp=%0d", tag, vc_o, vc); end
    total++; if ({cfg_err_o, seq_err_o} !== {model_cfg(mode, h), 1'b0}) begin bad++; $display("FAIL %s fs_err act=%0b exp=%0b", tag, {cfg_err_o, seq_err_o}, {model_cfg(mode, h), 1'b0}); end
    mode_i = 2'($urandom); h_size_i = HW'($urandom); vc_i = 2'($urandom);
    cyc(0, 0, 0, 0, 0);
    total++; if ({sp_en_o, cfg_err_o, dt_o} !== 8'h00) begin bad++; $display("FAIL %s fs_hold act=%0h exp=0", tag, {sp_en_o, cfg_err_o, dt_o}); end
    for (int l = 0; l < nlines; l++) begin
      n = wc + ((l == err_line) ? delta : 0);
      on_le = (n > 0) && ($urandom_range(0, 1) == 1);
      cyc(0, 0, 1, 0, 0);
      total++; if ({lp_en_o, sp_en_o, dt_o, vc_o} !== {2'b10, 6'(6'h2A + mode), 2'(vc)}) begin bad++; $display("FAIL %s ls_hdr act=%0h exp=%0h", tag, {lp_en_o, sp_en_o, dt_o, vc_o}, {2'b10, 6'(6'h2A + mode), 2'(vc)}); end
      total++; if (wc_o !== HW'(wc)) begin bad++; $display("FAIL %s ls_wc act=%0d exp=%0d", tag, wc_o, wc); end
      sent = 0;
      while (sent < n - int'(on_le)) begin
        e = ($urandom_range(0, 3) != 0);
        cyc(0, 0, 0, 0, e);
        sent += int'(e);
      end
      cyc(0, 0, 0, 1, on_le);
      total++; if ({len_err_o, seq_err_o, lp_en_o} !== {(n != wc), 2'b00}) begin bad++; $display("FAIL %s le_err act=%0b exp=%0b", tag, {len_err_o, seq_err_o, lp_en_o}, {(n != wc), 2'b00}); end
      total++; if (line_cnt_o !== 16'(l + 1)) begin bad++; $display("FAIL %s line_cnt act=%0d exp=%0d", tag, line_cnt_o, l + 1); end
      cyc(0, 0, 0, 0, 0);
      total++; if (len_err_o !== 1'b0) begin bad++; $display("FAIL %s len_pulse act=%0b exp=0", tag, len_err_o); end
    end
    cyc(0, 1, 0, 0, 0);
    total++; if ({sp_en_o, dt_o, len_err_o, seq_err_o} !== {1'b1, 6'h01, 2'b00}) begin bad++; $display("FAIL %s fe_hdr act=%0h exp=%0h", tag, {sp_en_o, dt_o, len_err_o, seq_err_o}, {1'b1, 6'h01, 2'b00}); end
    total++; if (wc_o !== HW'(fn)) begin bad++; $display("FAIL %s fe_wc act=%0d exp=%0d", tag, wc_o, fn); end
    frames_done++;
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge hf_clk90); reset_n_byte = 1'b0;
    cyc(0, 0, 0, 0, 0);
    @(negedge hf_clk90); reset_n_byte = 1'b1;
    frames_done = 0;
  endtask

  task automatic test_reset();
    cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 1);
    total++; if ({sp_en_o, lp_en_o, dt_o, vc_o, wc_o, line_cnt_o, len_err_o, seq_err_o, cfg_err_o, txfr_en_o, byte_en_o, byte_data_o} !== '0) begin bad++; $display("FAIL reset_outputs act=nonzero exp=0"); end
    @(negedge hf_clk90); reset_n_byte = 1'b1;
    cyc(0, 0, 0, 0, 0);
    total++; if ({sp_en_o, seq_err_o, wc_o} !== '0) begin bad++; $display("FAIL reset_idle act=%0h exp=0", {sp_en_o, seq_err_o, wc_o}); end
  endtask

  task automatic test_raw10_basic();
    run_frame(1, 256, 1, 2, -1, 0, "raw10");
  endtask

  task automatic test_raw12_len();
    run_frame(2, 100, 0, 1, -1, 0, "raw12_ok");
    run_frame(2, 100, 3, 1, 0, -1, "raw12_short");
  endtask

  task automatic test_fn_wrap();
    do_reset();
    for (int f = 0; f < 5; f++) run_frame(0, 8, f % 4, (f == 2) ? 8 : 1, -1, 0, "fn_wrap");
  endtask

  task automatic test_random_frames();
    int mode, h, nl, el, d;
    for (int f = 0; f < 6; f++) begin
      mode = $urandom_range(0, 2);
      h = 4 * $urandom_range(1, 16);
      nl = $urandom_range(1, 3);
      el = $urandom_range(0, 1) ? $urandom_range(0, nl - 1) : -1;
      d = $urandom_range(0, 1) ? int'($urandom_range(1, 3)) : -int'($urandom_range(1, 3));
      run_frame(mode, h, $urandom_range(0, 3), nl, el, d, "random");
    end
  endtask

  task automatic test_cfg();
    run_frame(1, 258, 2, 1, -1, 0, "cfg_raw10");
    run_frame(0, 0, 0, 1, -1, 0, "cfg_h0");
    mode_i = 2'd3; h_size_i = 16'd16;
    cyc(1, 0, 0, 0, 0);
    total++; if ({sp_en_o, cfg_err_o} !== 2'b11) begin bad++; $display("FAIL cfg_mode3 act=%0b exp=11", {sp_en_o, cfg_err_o}); end
    cyc(0, 1, 0, 0, 0);
    frames_done++;
  endtask

  task automatic test_seq_errors();
    cyc(0, 0, 1, 0, 0);
    total++; if ({seq_err_o, lp_en_o} !== 2'b10) begin bad++; $display("FAIL seq_ls_idle act=%0b exp=10", {seq_err_o, lp_en_o}); end
    cyc(0, 1, 0, 0, 0);
    total++; if ({seq_err_o, sp_en_o} !== 2'b10) begin bad++; $display("FAIL seq_fe_idle act=%0b exp=10", {seq_err_o, sp_en_o}); end
    cyc(0, 0, 0, 1, 0);
    total++; if (seq_err_o !== 1'b1) begin bad++; $display("FAIL seq_le_idle act=%0b exp=1", seq_err_o); end
    mode_i = 2'd0; h_size_i = 16'd8;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    total++; if ({seq_err_o, sp_en_o, dt_o} !== {2'b10, 6'h00}) begin bad++; $display("FAIL seq_fs_frame act=%0h exp=%0h", {seq_err_o, sp_en_o, dt_o}, {2'b10, 6'h00}); end
    cyc(0, 0, 0, 1, 0);
    total++; if ({seq_err_o, line_cnt_o} !== {1'b1, 16'd0}) begin bad++; $display("FAIL seq_le_frame act=%0h exp=%0h", {seq_err_o, line_cnt_o}, {1'b1, 16'd0}); end
    cyc(0, 0, 1, 1, 0);
    total++; if ({seq_err_o, lp_en_o, wc_o} !== {2'b11, 16'd8}) begin bad++; $display("FAIL seq_ls_le act=%0h exp=%0h", {seq_err_o, lp_en_o, wc_o}, {2'b11, 16'd8}); end
    for (int k = 0; k < 8; k++) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0);
    total++; if ({len_err_o, seq_err_o, line_cnt_o} !== {2'b00, 16'd1}) begin bad++; $display("FAIL seq_line_end act=%0h exp=%0h", {len_err_o, seq_err_o, line_cnt_o}, {2'b00, 16'd1}); end
    cyc(0, 1, 0, 0, 0);
    frames_done++;
  endtask

  task automatic test_fe_ls_same();
    int fn;
    mode_i = 2'd0; h_size_i = 16'd8;
    cyc(1, 0, 0, 0, 0);
    fn = model_fn();
    cyc(0, 1, 1, 0, 0);
    total++; if ({sp_en_o, lp_en_o, seq_err_o, dt_o} !== {3'b101, 6'h01}) begin bad++; $display("FAIL fe_ls_same act=%0h exp=%0h", {sp_en_o, lp_en_o, seq_err_o, dt_o}, {3'b101, 6'h01}); end
    total++; if (wc_o !== HW'(fn)) begin bad++; $display("FAIL fe_ls_wc act=%0d exp=%0d", wc_o, fn); end
    frames_done++;
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic test_fe_in_line();
    mode_i = 2'd0; h_size_i = 16'd8;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 1);
    total++; if ({sp_en_o, dt_o, len_err_o, seq_err_o} !== {1'b1, 6'h01, 2'b11}) begin bad++; $display("FAIL fe_in_line act=%0h exp=%0h", {sp_en_o, dt_o, len_err_o, seq_err_o}, {1'b1, 6'h01, 2'b11}); end
    frames_done++;
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_line();
    mode_i = 2'd1; h_size_i = 16'd16; vc_i = 2'd3;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 1);
    #2 reset_n_byte = 1'b0;
    #1;
    total++; if ({sp_en_o, lp_en_o, dt_o, vc_o, wc_o, line_cnt_o, len_err_o, seq_err_o, cfg_err_o, txfr_en_o, byte_en_o, byte_data_o} !== '0) begin bad++; $display("FAIL midline_reset act=nonzero exp=0"); end
    cyc(0, 0, 0, 0, 0);
    @(negedge hf_clk90); reset_n_byte = 1'b1;
    frames_done = 0;
    cyc(0, 0, 1, 0, 0);
    total++; if ({seq_err_o, lp_en_o, sp_en_o} !== 3'b100) begin bad++; $display("FAIL post_reset_ls act=%0b exp=100", {seq_err_o, lp_en_o, sp_en_o}); end
    cyc(0, 0, 0, 0, 0);
    total++; if ({sp_en_o, seq_err_o} !== 2'b00) begin bad++; $display("FAIL post_reset_no_fe act=%0b exp=00", {sp_en_o, seq_err_o}); end
    run_frame(0, 8, 0, 1, -1, 0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_raw10_basic();
    test_raw12_len();
    test_fn_wrap();
    test_random_frames();
    test_cfg();
    test_seq_errors();
    test_fe_ls_same();
    test_fe_in_line();
    test_reset_mid_line();
    cyc(0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
